// File: rtl/pipe_add_sub_pkg.sv
// pipe_add_sub_pkg: shared helpers for the pipelined adder/subtractor
package pipe_add_sub_pkg;
  function automatic int slice_w(input int width, input int stages);
    return (stages < 1) ? width : width / stages;
  endfunction
endpackage

// File: rtl/pipe_add_sub_if.sv
// pipe_add_sub_if: operand stream in, result stream out, both valid/ready
interface pipe_add_sub_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, in_sub, in_cin;
  logic [WIDTH-1:0] in_a, in_b;
  logic out_valid, out_ready, out_cout, out_ovf;
  logic [WIDTH-1:0] out_sum;
  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/pipe_add_sub_add_slice.sv
// add_slice: combinational W-bit full adder exposing carry into its MSB
module add_slice #(parameter int W = 4) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);
  logic [W:0] full;
  assign full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  assign sum  = full[W-1:0];
  assign cout = full[W];
  assign cmsb = a[W-1] ^ b[W-1] ^ full[W-1];
endmodule

// File: rtl/pipe_add_sub.sv
// pipe_add_sub: skewed carry-chained add/sub, one slice per stage, valid/ready flow
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst_n,
  pipe_add_sub_if.slave bus
);
  localparam int S = slice_w(WIDTH, STAGES);
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             cmsb;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;
  if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_params
    $error("pipe_add_sub: WIDTH must be a positive multiple of STAGES");
  end
  stage_t st [STAGES];
  stage_t src [STAGES];
  stage_t nxt [STAGES];
  logic [S-1:0] sl_sum [STAGES];
  logic sl_co [STAGES];
  logic sl_cm [STAGES];
  logic [STAGES:0] adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src[k] = '{valid: bus.in_valid, carry: bus.in_sub | bus.in_cin, cmsb: 1'b0,
                        sum: '0, a: bus.in_a, b: bus.in_sub ? ~bus.in_b : bus.in_b};
    end else begin : g_rest
      assign src[k] = st[k-1];
    end
    add_slice #(.W(S)) u_slice (
      .a   (src[k].a[k*S +: S]),
      .b   (src[k].b[k*S +: S]),
      .cin (src[k].carry),
      .sum (sl_sum[k]),
      .cout(sl_co[k]),
      .cmsb(sl_cm[k])
    );
  end
  // Merge each slice result into the transaction travelling through its stage
  always_comb
    for (int k = 0; k < STAGES; k++) begin
      nxt[k] = src[k];
      nxt[k].carry = sl_co[k];
      nxt[k].cmsb = sl_cm[k];
      nxt[k].sum[k*S +: S] = sl_sum[k];
    end
  // A stage moves when it is empty or its successor moves; the tail moves on out_ready
  always_comb begin
    adv[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) adv[k] = ~st[k].valid | adv[k+1];
  end
  // Stage registers; reset drops every in-flight operation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int k = 0; k < STAGES; k++) st[k] <= '0;
    else
      for (int k = 0; k < STAGES; k++) if (adv[k]) st[k] <= nxt[k];
  assign bus.in_ready  = adv[0];
  assign bus.out_valid = st[STAGES-1].valid;
  assign bus.out_sum   = st[STAGES-1].sum;
  assign bus.out_cout  = st[STAGES-1].carry;
  assign bus.out_ovf   = st[STAGES-1].carry ^ st[STAGES-1].cmsb;
endmodule

// File: tb/tb_pipe_add_sub.sv
// tb_pipe_add_sub: random and directed checks of pipe_add_sub against an arithmetic model
module tb_pipe_add_sub;
  logic clk, rst_n;
  int n_tests, n_fail;
  logic mon_en, chk_rdy, held_v;
  logic [18:0] held;
  logic [17:0] q [$];
  pipe_add_sub_if #(.WIDTH(16)) b0 ();
  pipe_add_sub_if #(.WIDTH(16)) b1 ();
  pipe_add_sub_if #(.WIDTH(8))  b2 ();
  pipe_add_sub #(.WIDTH(16), .STAGES(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  pipe_add_sub #(.WIDTH(16), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  pipe_add_sub #(.WIDTH(8),  .STAGES(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic c);
    longint m, ua, ub, sa, sb, u, r;
    logic co, ov;
    m  = longint'(1) << w;
    ua = longint'(a) % m;
    ub = longint'(b) % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    u  = s ? ua - ub : ua + ub + longint'(c);
    co = s ? (ua >= ub) : (u >= m);
    r  = s ? sa - sb : sa + sb + longint'(c);
    ov = (r >= m / 2) || (r < -(m / 2));
    u  = (u + m) % m;
    return {ov, co, 16'(u)};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input int bound);
    for (int i = 0; i < bound && q.size() > 0; i++) tick;
    chk("drain_empty", q.size(), 0);
  endtask
  task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic [7:0] a8,
                          input logic [7:0] b8, input logic s, input logic c);
    int lat [3];
    logic [17:0] r [3];
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0;
      r[i] = '0;
    end
    b0.in_valid = 1; b0.in_a = a;  b0.in_b = b;  b0.in_sub = s; b0.in_cin = c;
    b1.in_valid = 1; b1.in_a = a;  b1.in_b = b;  b1.in_sub = s; b1.in_cin = c;
    b2.in_valid = 1; b2.in_a = a8; b2.in_b = b8; b2.in_sub = s; b2.in_cin = c;
    tick;
    b0.in_valid = 0; b1.in_valid = 0; b2.in_valid = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (b0.out_valid && lat[0] == 0) begin lat[0] = n; r[0] = {b0.out_ovf, b0.out_cout, b0.out_sum}; end
      if (b1.out_valid && lat[1] == 0) begin lat[1] = n; r[1] = {b1.out_ovf, b1.out_cout, b1.out_sum}; end
      if (b2.out_valid && lat[2] == 0) begin lat[2] = n; r[2] = {b2.out_ovf, b2.out_cout, 8'h00, b2.out_sum}; end
    end
    chk("lat_w16_s4", lat[0], 4);
    chk("res_w16_s4", r[0], model(16, a, b, s, c));
    chk("lat_w16_s1", lat[1], 1);
    chk("res_w16_s1", r[1], model(16, a, b, s, c));
    chk("lat_w8_s8", lat[2], 8);
    chk("res_w8_s8", r[2], model(8, {8'h00, a8}, {8'h00, b8}, s, c));
    tick;
  endtask
  always @(negedge clk)
    if (mon_en) begin
      if (held_v) chk("held_output", {b0.out_valid, b0.out_ovf, b0.out_cout, b0.out_sum}, {1'b1, held[17:0]});
      held_v = b0.out_valid & ~b0.out_ready;
      held = {1'b1, b0.out_ovf, b0.out_cout, b0.out_sum};
      if (chk_rdy) chk("stream_in_ready", b0.in_ready, 1);
      if (b0.out_valid && b0.out_ready) begin
        if (q.size() == 0) chk("spurious_result", 1, 0);
        else chk("result", {b0.out_ovf, b0.out_cout, b0.out_sum}, q.pop_front());
      end
      if (b0.in_valid && b0.in_ready) q.push_back(model(16, b0.in_a, b0.in_b, b0.in_sub, b0.in_cin));
    end else begin
      held_v = 0;
      q.delete();
    end
  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int seen;
    n_tests = 0; n_fail = 0; mon_en = 0; chk_rdy = 0; held_v = 0; held = '0;
    clk = 0; rst_n = 0;
    b0.in_valid = 1; b0.in_a = 16'h1234; b0.in_b = 16'h4321; b0.in_sub = 0; b0.in_cin = 1; b0.out_ready = 1;
    b1.in_valid = 1; b1.in_a = 16'h1234; b1.in_b = 16'h4321; b1.in_sub = 0; b1.in_cin = 1; b1.out_ready = 1;
    b2.in_valid = 1; b2.in_a = 8'h12;    b2.in_b = 8'h34;    b2.in_sub = 0; b2.in_cin = 1; b2.out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_out_sum", b0.out_sum, 0);
    chk("rst_out_flags", {b0.out_cout, b0.out_ovf}, 0);
    chk("rst_in_ready", b0.in_ready, 1);
    chk("rst_out_valid_s1", b1.out_valid, 0);
    chk("rst_out_valid_s8", b2.out_valid, 0);
    tick;
    b0.in_valid = 0; b1.in_valid = 0; b2.in_valid = 0;
    rst_n = 1;
    tick;
    directed(16'hFFFF, 16'h0001, 8'hFF, 8'h01, 0, 0);
    directed(16'h7FFF, 16'h0000, 8'h7F, 8'h00, 0, 1);
    directed(16'h0005, 16'h0007, 8'h05, 8'h07, 1, 0);
    directed(16'h8000, 16'h0001, 8'h80, 8'h01, 1, 1);
    mon_en = 1; chk_rdy = 1;
    for (int i = 0; i < 100; i++) begin
      b0.in_valid = 1; b0.in_a = 16'($urandom); b0.in_b = 16'($urandom);
      b0.in_sub = 1'($urandom); b0.in_cin = 1'($urandom);
      tick;
    end
    b0.in_valid = 0; chk_rdy = 0;
    drain(20);
    for (int i = 0; i < 300; i++) begin
      b0.in_valid = 1'($urandom); b0.in_a = 16'($urandom); b0.in_b = 16'($urandom);
      b0.in_sub = 1'($urandom); b0.in_cin = 1'($urandom); b0.out_ready = 1'($urandom);
      tick;
    end
    b0.out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      b0.in_valid = 1; b0.in_a = 16'($urandom); b0.in_b = 16'($urandom);
      b0.in_sub = 1'($urandom); b0.in_cin = 1'($urandom);
      tick;
    end
    @(negedge clk);
    chk("full_in_ready", b0.in_ready, 0);
    chk("full_out_valid", b0.out_valid, 1);
    tick;
    b0.in_valid = 0; b0.out_ready = 1;
    drain(30);
    for (int i = 0; i < 6; i++) begin
      b0.in_valid = 1; b0.in_a = 16'($urandom); b0.in_b = 16'($urandom);
      b0.in_sub = 1'($urandom); b0.in_cin = 1'($urandom);
      tick;
    end
    rst_n = 0; mon_en = 0; b0.in_valid = 0;
    tick;
    @(negedge clk);
    chk("midrst_out_valid", b0.out_valid, 0);
    tick;
    rst_n = 1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (b0.out_valid) seen++;
    end
    chk("post_reset_emerge", seen, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_add_sub.md
Name: pipe_add_sub

Overview:
Parametrised, pipelined two's-complement adder/subtractor that generalises the team's 4-bit ripple adder. It splits a WIDTH-bit operation into STAGES carry-chained slices, one slice per pipeline stage. Operand bits are skewed so one new operation can be accepted every cycle. Valid/ready handshakes on input and output allow it to sit between streaming datapath blocks under backpressure.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages and slices; 1..WIDTH. SLICE = WIDTH/STAGES bits per slice.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operation presented.
in_ready  output  1  block can accept this cycle.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_sub  input  1  1 = A - B, 0 = A + B + in_cin.
in_cin  input  1  carry-in; used only when in_sub = 0.
out_valid  output  1  result present.
out_ready  input  1  downstream accepts this cycle.
out_sum  output  WIDTH  result, mod 2^WIDTH.
out_cout  output  1  carry-out of MSB; for subtract, 1 = no borrow (A >= B unsigned).
out_ovf  output  1  signed overflow.

Behaviour:
- Reset (async assert, sync-clean deassert by design): all stage valid bits = 0, out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, in_ready = 1. Data registers may also be cleared; no output may depend on stale data.
- Operand prep at acceptance: B' = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
- Stage k (0..STAGES-1) adds slice k of A and B' plus the carry from stage k-1 (c0 for k=0). It registers the SLICE-bit sum, carry, and valid, and forwards the not-yet-summed upper slices of A/B'.
- Lower result slices are carried forward alongside the transaction, so the output register holds the full aligned result.
- Latency: accepted on cycle t (in_valid & in_ready), out_valid = 1 from cycle t + STAGES if never stalled.
- Throughput: one op/cycle when out_ready is held 1.
- Backpressure: stage k advances when it is empty or stage k+1 advances. The last stage advances on out_ready or when empty. in_ready = stage-0 advance condition, i.e. combinational from out_ready through the chain (no skid buffer). Bubbles compress under stall.
- Held output: while out_valid & ~out_ready, out_sum/out_cout/out_ovf are stable.
- Flags are computed from the final slice:
  - out_cout = MSB carry-out.
  - out_ovf = carry into MSB XOR carry out of MSB.
- Boundaries:
  - Wrap-around is modulo 2^WIDTH; no saturation.
  - STAGES = 1 gives a single registered adder with latency 1.
  - STAGES = WIDTH gives a bit-serial-per-stage pipeline.
  - Simultaneous accept at the input and drain at the output in the same cycle is legal and loses nothing.
  - If in_valid is 0, in_a/in_b/in_sub/in_cin are don't-care.
  - rst_n asserted mid-operation drops all in-flight ops immediately; nothing emerges after release.
- Parameter check: elaboration-time error if WIDTH % STAGES != 0 or STAGES < 1.

Decomposition:
- Shared package: the SLICE derivation helper, and a struct/typedef for the per-stage payload: valid, carry, partial-sum vector, and remaining A/B' vectors. Declare it with parametrised widths, or as localparams in the module if the package cannot be parametrised.
- One sub-module, add_slice: a combinational SLICE-bit full adder (a, b, cin -> sum, cout, plus carry into its MSB for overflow). It is instantiated STAGES times inside a generate loop. Pipeline registers and handshake logic stay in pipe_add_sub.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_sum=0, in_ready=1. After release, first result appears exactly 4 cycles after first accept.
- Add with carry: A=0xFFFF, B=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1, ovf=0. Also A=0x7FFF, B=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Subtract: A=0x0005, B=0x0007, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Also A=0x8000, B=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Streaming: 100 back-to-back random ops with out_ready=1 -> one result per cycle in order, matching the reference model, in_ready constantly 1.
- Backpressure: random out_ready (50%) with random in_valid -> no drop or duplicate, order preserved, outputs stable while stalled. With pipe full and out_ready=0, in_ready=0.
- Corners: rerun the add/sub vectors with STAGES=1 (latency 1) and WIDTH=8, STAGES=8 (latency 8). Assert rst_n mid-stream -> no result emerges after release.
